// File: rtl/trig_cmd_pkg.sv
// Shared definitions for the multi-channel trigger command engine.
// Holds the opcode byte values, reply codes, the broadcast channel id,
// the per-channel edge/mode types and the parser state encoding.
package trig_cmd_pkg;

  localparam logic [7:0] OP_SET_COARSE  = 8'h01;
  localparam logic [7:0] OP_GET_COARSE  = 8'h02;
  localparam logic [7:0] OP_SET_EDGE    = 8'h03;
  localparam logic [7:0] OP_GET_EDGE    = 8'h04;
  localparam logic [7:0] OP_GET_STATUS  = 8'h05;
  localparam logic [7:0] OP_RESET_COUNT = 8'h06;
  localparam logic [7:0] OP_SET_FINE    = 8'h07;
  localparam logic [7:0] OP_GET_FINE    = 8'h08;
  localparam logic [7:0] OP_SET_MODE    = 8'h09;
  localparam logic [7:0] OP_ARM         = 8'h0A;

  localparam logic [7:0] ACK   = 8'hA5;
  localparam logic [7:0] NAK   = 8'h5A;
  localparam logic [7:0] BCAST = 8'hFF;

  typedef enum logic [1:0] {
    EDGE_NONE    = 2'd0,
    EDGE_RISING  = 2'd1,
    EDGE_FALLING = 2'd2,
    EDGE_BOTH    = 2'd3
  } edge_t;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAN,
    S_PAYLOAD,
    S_EXEC,
    S_TX
  } state_t;

  // Opcodes form one contiguous range 0x01..0x0A.
  function automatic logic op_known(input logic [7:0] op);
    return (op >= OP_SET_COARSE) && (op <= OP_ARM);
  endfunction

endpackage

// File: rtl/trig_ch_regs.sv
// Per-channel register bank for one trigger delay channel.
// Holds coarse/fine delay, edge select, fire mode, arm flag and a
// saturating trigger counter; generates the one-cycle update strobes.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_we_coarse/i_we_fine      load coarse/fine delay (strobe follows next cycle with data)
//   i_we_edge/i_we_mode        load edge select / mode from i_byte
//   i_arm                      set armed
//   i_clr_cnt                  clear trigger counter (beats a coincident i_trig)
//   i_coarse/i_fine/i_byte     write data
//   i_trig, i_fire             detected-edge pulse, delayed-output fire pulse
//   o_coarse .. o_cnt          current register values and update strobes
module trig_ch_regs
  import trig_cmd_pkg::*;
#(
  parameter int COARSE_W = 32,
  parameter int FINE_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we_coarse,
  input  logic                i_we_fine,
  input  logic                i_we_edge,
  input  logic                i_we_mode,
  input  logic                i_arm,
  input  logic                i_clr_cnt,
  input  logic [COARSE_W-1:0] i_coarse,
  input  logic [FINE_W-1:0]   i_fine,
  input  logic [7:0]          i_byte,
  input  logic                i_trig,
  input  logic                i_fire,
  output logic [COARSE_W-1:0] o_coarse,
  output logic                o_coarse_upd,
  output logic [FINE_W-1:0]   o_fine,
  output logic                o_fine_upd,
  output logic [1:0]          o_edge,
  output logic                o_mode,
  output logic                o_armed,
  output logic [CNT_W-1:0]    o_cnt
);

  logic [COARSE_W-1:0] r_coarse;
  logic                r_coarse_upd;
  logic [FINE_W-1:0]   r_fine;
  logic                r_fine_upd;
  edge_t               r_edge;
  mode_t               r_mode;
  logic                r_armed;
  logic [CNT_W-1:0]    r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coarse     <= '0;
      r_coarse_upd <= 1'b0;
      r_fine       <= '0;
      r_fine_upd   <= 1'b0;
      r_edge       <= EDGE_RISING;
      r_mode       <= MODE_CONT;
      r_armed      <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_coarse_upd <= i_we_coarse;
      r_fine_upd   <= i_we_fine;
      if (i_we_coarse) r_coarse <= i_coarse;
      if (i_we_fine)   r_fine   <= i_fine;
      // Out-of-range edge codes fall back to the reset default.
      if (i_we_edge)
        r_edge <= (i_byte > 8'd3) ? EDGE_RISING : edge_t'(i_byte[1:0]);
      if (i_we_mode)
        r_mode <= (i_byte == 8'd0) ? MODE_CONT : MODE_ONESHOT;
      // Arming (explicit or by returning to continuous) beats a same-cycle fire.
      if (i_arm || (i_we_mode && (i_byte == 8'd0)))
        r_armed <= 1'b1;
      else if (i_fire && (r_mode == MODE_ONESHOT))
        r_armed <= 1'b0;
      if (i_clr_cnt)
        r_cnt <= '0;
      else if (i_trig && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_coarse     = r_coarse;
  assign o_coarse_upd = r_coarse_upd;
  assign o_fine       = r_fine;
  assign o_fine_upd   = r_fine_upd;
  assign o_edge       = r_edge;
  assign o_mode       = r_mode;
  assign o_armed      = r_armed;
  assign o_cnt        = r_cnt;

endmodule

// File: rtl/trig_multi_ch_ctrl.sv
// Byte-stream command engine for N_CH trigger delay channels.
// Parses OPCODE, CHAN, payload (LSB first) from the UART RX side, applies
// writes to the per-channel register banks, and returns ACK/NAK or read
// data on the UART TX side. Partial commands are aborted after
// TIMEOUT_CYC idle cycles between bytes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   tx_data, tx_en      transmit byte and its one-cycle strobe
//   tx_ready            UART TX idle
//   trig_pulse          per-channel detected-edge pulse (counter input)
//   fire_pulse          per-channel delayed-output fire pulse
//   coarse_delay/coarse_update, fine_delay_ps/fine_update
//                       per-channel delays with coincident update strobes
//   edge_type           per-channel edge select, 2 bits per channel
//   armed               per-channel arm flag
module trig_multi_ch_ctrl
  import trig_cmd_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int COARSE_W    = 32,
  parameter int FINE_W      = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_en,
  input  logic                     tx_ready,
  input  logic [N_CH-1:0]          trig_pulse,
  input  logic [N_CH-1:0]          fire_pulse,
  output logic [N_CH*COARSE_W-1:0] coarse_delay,
  output logic [N_CH-1:0]          coarse_update,
  output logic [N_CH*FINE_W-1:0]   fine_delay_ps,
  output logic [N_CH-1:0]          fine_update,
  output logic [N_CH*2-1:0]        edge_type,
  output logic [N_CH-1:0]          armed
);

  localparam int PAY_W  = (COARSE_W > FINE_W) ? COARSE_W : FINE_W;
  localparam int PCNT_W = $clog2(PAY_W/8 + 1);
  localparam int RSP_W  = CNT_W + COARSE_W + FINE_W + 8;
  localparam int RSP_B  = RSP_W / 8;
  localparam int RCNT_W = $clog2(RSP_B + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

  function automatic logic [PCNT_W-1:0] pay_len(input logic [7:0] op);
    case (op)
      OP_SET_COARSE: return PCNT_W'(COARSE_W/8);
      OP_SET_FINE:   return PCNT_W'(FINE_W/8);
      OP_SET_EDGE,
      OP_SET_MODE:   return PCNT_W'(1);
      default:       return '0;
    endcase
  endfunction

  state_t              r_state;
  logic [7:0]          r_op;
  logic [7:0]          r_chan;
  logic [PAY_W-1:0]    r_pay;
  logic [PCNT_W-1:0]   r_pay_cnt;
  logic [PCNT_W-1:0]   r_pay_len;
  logic [TMR_W-1:0]    r_tmr;
  logic [RSP_W-1:0]    r_rsp;
  logic [RCNT_W-1:0]   r_rsp_cnt;
  logic                r_tx_wait;
  logic                r_tx_en;
  logic [7:0]          r_tx_data;

  logic                w_exec;
  logic                w_bcast;
  logic                w_valid;
  logic [N_CH-1:0]     w_hit;
  logic [N_CH-1:0]     w_we_coarse;
  logic [N_CH-1:0]     w_we_fine;
  logic [N_CH-1:0]     w_we_edge;
  logic [N_CH-1:0]     w_we_mode;
  logic [N_CH-1:0]     w_arm;
  logic [N_CH-1:0]     w_clr_cnt;
  logic                w_mode [N_CH];
  logic [CNT_W-1:0]    w_cnt  [N_CH];

  logic [COARSE_W-1:0] w_sel_coarse;
  logic [FINE_W-1:0]   w_sel_fine;
  logic [1:0]          w_sel_edge;
  logic                w_sel_mode;
  logic                w_sel_armed;
  logic [CNT_W-1:0]    w_sel_cnt;

  // Command validation: only group commands may address the broadcast id.
  assign w_exec  = (r_state == S_EXEC);
  assign w_bcast = (r_chan == BCAST);
  assign w_valid = (int'(r_chan) < N_CH) ||
                   (w_bcast && ((r_op == OP_RESET_COUNT) || (r_op == OP_ARM) ||
                                (r_op == OP_SET_MODE)));

  always_comb begin
    w_hit       = '0;
    w_we_coarse = '0;
    w_we_fine   = '0;
    w_we_edge   = '0;
    w_we_mode   = '0;
    w_arm       = '0;
    w_clr_cnt   = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_hit[c]       = w_exec && w_valid && (w_bcast || (int'(r_chan) == c));
      w_we_coarse[c] = w_hit[c] && (r_op == OP_SET_COARSE);
      w_we_fine[c]   = w_hit[c] && (r_op == OP_SET_FINE);
      w_we_edge[c]   = w_hit[c] && (r_op == OP_SET_EDGE);
      w_we_mode[c]   = w_hit[c] && (r_op == OP_SET_MODE);
      w_arm[c]       = w_hit[c] && (r_op == OP_ARM);
      w_clr_cnt[c]   = w_hit[c] && (r_op == OP_RESET_COUNT);
    end
  end

  // Read-back mux for the addressed channel, sampled during EXEC.
  always_comb begin
    w_sel_coarse = '0;
    w_sel_fine   = '0;
    w_sel_edge   = '0;
    w_sel_mode   = 1'b0;
    w_sel_armed  = 1'b0;
    w_sel_cnt    = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(r_chan) == c) begin
        w_sel_coarse = coarse_delay[c*COARSE_W +: COARSE_W];
        w_sel_fine   = fine_delay_ps[c*FINE_W +: FINE_W];
        w_sel_edge   = edge_type[c*2 +: 2];
        w_sel_mode   = w_mode[c];
        w_sel_armed  = armed[c];
        w_sel_cnt    = w_cnt[c];
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    trig_ch_regs #(
      .COARSE_W (COARSE_W),
      .FINE_W   (FINE_W),
      .CNT_W    (CNT_W)
    ) u_regs (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_we_coarse  (w_we_coarse[c]),
      .i_we_fine    (w_we_fine[c]),
      .i_we_edge    (w_we_edge[c]),
      .i_we_mode    (w_we_mode[c]),
      .i_arm        (w_arm[c]),
      .i_clr_cnt    (w_clr_cnt[c]),
      .i_coarse     (r_pay[COARSE_W-1:0]),
      .i_fine       (r_pay[FINE_W-1:0]),
      .i_byte       (r_pay[7:0]),
      .i_trig       (trig_pulse[c]),
      .i_fire       (fire_pulse[c]),
      .o_coarse     (coarse_delay[c*COARSE_W +: COARSE_W]),
      .o_coarse_upd (coarse_update[c]),
      .o_fine       (fine_delay_ps[c*FINE_W +: FINE_W]),
      .o_fine_upd   (fine_update[c]),
      .o_edge       (edge_type[c*2 +: 2]),
      .o_mode       (w_mode[c]),
      .o_armed      (armed[c]),
      .o_cnt        (w_cnt[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_chan    <= '0;
      r_pay     <= '0;
      r_pay_cnt <= '0;
      r_pay_len <= '0;
      r_tmr     <= '0;
      r_rsp     <= '0;
      r_rsp_cnt <= '0;
      r_tx_wait <= 1'b0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_en <= 1'b0;
      // Seeing tx_ready low proves the UART took the last byte.
      if (!tx_ready) r_tx_wait <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_op  <= rx_data;
            r_tmr <= '0;
            if (op_known(rx_data)) begin
              r_pay_len <= pay_len(rx_data);
              r_state   <= S_CHAN;
            end else begin
              r_rsp     <= RSP_W'(NAK);
              r_rsp_cnt <= RCNT_W'(1);
              r_state   <= S_TX;
            end
          end
        end

        S_CHAN, S_PAYLOAD: begin
          if (rx_valid) begin
            r_tmr <= '0;
            if (r_state == S_CHAN) begin
              r_chan    <= rx_data;
              r_pay     <= '0;
              r_pay_cnt <= '0;
              r_state   <= (r_pay_len == '0) ? S_EXEC : S_PAYLOAD;
            end else begin
              r_pay[{r_pay_cnt, 3'b000} +: 8] <= rx_data;
              r_pay_cnt <= r_pay_cnt + 1'b1;
              if (r_pay_cnt == r_pay_len - 1'b1) r_state <= S_EXEC;
            end
          end else if (r_tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end

        S_EXEC: begin
          r_state <= S_TX;
          if (!w_valid) begin
            r_rsp     <= RSP_W'(NAK);
            r_rsp_cnt <= RCNT_W'(1);
          end else begin
            case (r_op)
              OP_GET_COARSE: begin
                r_rsp     <= RSP_W'(w_sel_coarse);
                r_rsp_cnt <= RCNT_W'(COARSE_W/8);
              end
              OP_GET_FINE: begin
                r_rsp     <= RSP_W'(w_sel_fine);
                r_rsp_cnt <= RCNT_W'(FINE_W/8);
              end
              OP_GET_EDGE: begin
                r_rsp     <= RSP_W'(w_sel_edge);
                r_rsp_cnt <= RCNT_W'(1);
              end
              OP_GET_STATUS: begin
                r_rsp     <= {4'b0000, w_sel_mode, w_sel_armed, w_sel_edge,
                              w_sel_fine, w_sel_coarse, w_sel_cnt};
                r_rsp_cnt <= RCNT_W'(RSP_B);
              end
              default: begin
                r_rsp     <= RSP_W'(ACK);
                r_rsp_cnt <= RCNT_W'(1);
              end
            endcase
          end
        end

        S_TX: begin
          if (!r_tx_wait && tx_ready) begin
            r_tx_en   <= 1'b1;
            r_tx_data <= r_rsp[7:0];
            r_rsp     <= r_rsp >> 8;
            r_rsp_cnt <= r_rsp_cnt - 1'b1;
            r_tx_wait <= 1'b1;
            if (r_rsp_cnt == RCNT_W'(1)) r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_en   = r_tx_en;
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_trig_multi_ch_ctrl.sv
module tb_trig_multi_ch_ctrl;

  localparam int NC   = 4;
  localparam int TOUT = 200;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_ready;
  logic [3:0]  trig_pulse;
  logic [3:0]  fire_pulse;
  logic [127:0] coarse_delay;
  logic [3:0]  coarse_update;
  logic [63:0] fine_delay_ps;
  logic [3:0]  fine_update;
  logic [7:0]  edge_type;
  logic [3:0]  armed;

  trig_multi_ch_ctrl #(
    .N_CH(NC), .COARSE_W(32), .FINE_W(16), .CNT_W(8), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_en(tx_en), .tx_ready(tx_ready),
    .trig_pulse(trig_pulse), .fire_pulse(fire_pulse),
    .coarse_delay(coarse_delay), .coarse_update(coarse_update),
    .fine_delay_ps(fine_delay_ps), .fine_update(fine_update),
    .edge_type(edge_type), .armed(armed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int n_cupd   = 0;
  logic [7:0] rsp_q[$];
  logic [7:0] exp_q[$];

  // Reference state of each channel, as seen through the command interface.
  logic [31:0] m_coarse[NC];
  logic [15:0] m_fine[NC];
  logic [1:0]  m_edge[NC];
  bit          m_mode[NC];
  bit          m_armed[NC];
  int          m_cnt[NC];

  // Byte capture and update-strobe counting.
  always @(negedge clk) begin
    if (tx_en) rsp_q.push_back(tx_data);
    if (|coarse_update) n_cupd++;
  end

  // UART TX emulation: busy for a few cycles after every accepted byte.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tx_en) begin
        tx_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        tx_ready = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_coarse[c] = '0; m_fine[c] = '0; m_edge[c] = 2'd1;
      m_mode[c] = 1'b0; m_armed[c] = 1'b1; m_cnt[c] = 0;
    end
  endtask

  function automatic int plen(input logic [7:0] op);
    case (op)
      8'h01: return 4;
      8'h07: return 2;
      8'h03, 8'h09: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_cmd(input logic [7:0] op, input logic [7:0] ch, input logic [63:0] pay);
    bit bc;
    bit ok;
    exp_q.delete();
    if (op < 8'h01 || op > 8'h0A) begin
      exp_q.push_back(8'h5A);
      return;
    end
    bc = (ch == 8'hFF);
    ok = (ch < NC) || (bc && (op == 8'h06 || op == 8'h09 || op == 8'h0A));
    if (!ok) begin
      exp_q.push_back(8'h5A);
      return;
    end
    case (op)
      8'h02: for (int i = 0; i < 4; i++) exp_q.push_back(m_coarse[ch][8*i +: 8]);
      8'h04: exp_q.push_back({6'd0, m_edge[ch]});
      8'h08: for (int i = 0; i < 2; i++) exp_q.push_back(m_fine[ch][8*i +: 8]);
      8'h05: begin
        exp_q.push_back(8'(m_cnt[ch]));
        for (int i = 0; i < 4; i++) exp_q.push_back(m_coarse[ch][8*i +: 8]);
        for (int i = 0; i < 2; i++) exp_q.push_back(m_fine[ch][8*i +: 8]);
        exp_q.push_back({4'd0, m_mode[ch], m_armed[ch], m_edge[ch]});
      end
      default: exp_q.push_back(8'hA5);
    endcase
    for (int c = 0; c < NC; c++) begin
      if (bc || c == int'(ch)) begin
        case (op)
          8'h01: m_coarse[c] = pay[31:0];
          8'h03: m_edge[c] = (pay[7:0] > 8'd3) ? 2'd1 : pay[1:0];
          8'h06: m_cnt[c] = 0;
          8'h07: m_fine[c] = pay[15:0];
          8'h09: begin
            m_mode[c] = (pay[7:0] != 8'd0);
            if (pay[7:0] == 8'd0) m_armed[c] = 1'b1;
          end
          8'h0A: m_armed[c] = 1'b1;
          default: ;
        endcase
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] ch, input logic [63:0] pay);
    send_byte(op);
    if (op >= 8'h01 && op <= 8'h0A) begin
      send_byte(ch);
      for (int i = 0; i < plen(op); i++) send_byte(pay[8*i +: 8]);
    end
  endtask

  task automatic wait_reply(input string tag);
    int n;
    int k;
    n = exp_q.size();
    k = 0;
    while (rsp_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    check({tag, "_len"}, 64'(rsp_q.size()), 64'(n));
    for (int i = 0; i < n && i < rsp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 64'(rsp_q[i]), 64'(exp_q[i]));
    rsp_q.delete();
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] op, input logic [7:0] ch,
                        input logic [63:0] pay);
    send_frame(op, ch, pay);
    model_cmd(op, ch, pay);
    wait_reply(tag);
  endtask

  task automatic pulse_trig(input logic [3:0] mask, input int n);
    @(negedge clk);
    trig_pulse = mask;
    repeat (n) @(negedge clk);
    trig_pulse = '0;
    for (int c = 0; c < NC; c++)
      if (mask[c]) m_cnt[c] = (m_cnt[c] + n > 255) ? 255 : m_cnt[c] + n;
  endtask

  task automatic pulse_fire(input logic [3:0] mask);
    @(negedge clk);
    fire_pulse = mask;
    @(negedge clk);
    fire_pulse = '0;
    for (int c = 0; c < NC; c++)
      if (mask[c] && m_mode[c]) m_armed[c] = 1'b0;
  endtask

  task automatic compare_outputs(input string tag);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s_coarse%0d", tag, c), 64'(coarse_delay[c*32 +: 32]), 64'(m_coarse[c]));
      check($sformatf("%s_fine%0d", tag, c), 64'(fine_delay_ps[c*16 +: 16]), 64'(m_fine[c]));
      check($sformatf("%s_edge%0d", tag, c), 64'(edge_type[c*2 +: 2]), 64'(m_edge[c]));
      check($sformatf("%s_armed%0d", tag, c), 64'(armed[c]), 64'(m_armed[c]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"}, 64'(tx_en), 64'd0);
    check({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    check({tag, "_cupd"}, 64'(coarse_update), 64'd0);
    check({tag, "_fupd"}, 64'(fine_update), 64'd0);
    check({tag, "_coarse_hi"}, coarse_delay[127:64], 64'd0);
    check({tag, "_coarse_lo"}, coarse_delay[63:0], 64'd0);
    check({tag, "_fine"}, fine_delay_ps, 64'd0);
    check({tag, "_edge"}, 64'(edge_type), 64'h55);
    check({tag, "_armed"}, 64'(armed), 64'hF);
  endtask

  initial begin
    int cupd0;
    logic [7:0]  op;
    logic [7:0]  ch;
    logic [63:0] pay;
    int r;

    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
    trig_pulse = '0; fire_pulse = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Coarse write with update-strobe timing.
    send_frame(8'h01, 8'h02, 64'h12345678);
    check("cupd_t1", 64'(coarse_update), 64'd0);
    @(negedge clk);
    check("cupd_t2", 64'(coarse_update), 64'b0100);
    check("coarse2_t2", 64'(coarse_delay[64 +: 32]), 64'h12345678);
    @(negedge clk);
    check("cupd_t3", 64'(coarse_update), 64'd0);
    model_cmd(8'h01, 8'h02, 64'h12345678);
    wait_reply("set_coarse");

    // Reset in the middle of a frame.
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h10);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_mid");
    rsp_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_cmd("get_coarse_after_rst", 8'h02, 8'h02, 64'd0);

    // Bad channel: NAK only after full payload, no update.
    cupd0 = n_cupd;
    send_byte(8'h01); send_byte(8'h07);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    repeat (6) @(negedge clk);
    check("nak_not_early", 64'(rsp_q.size()), 64'd0);
    send_byte(8'h44);
    model_cmd(8'h01, 8'h07, 64'h44332211);
    wait_reply("nak_chan");
    check("nak_no_cupd", 64'(n_cupd - cupd0), 64'd0);
    do_cmd("nak_op", 8'h3F, 8'h00, 64'd0);
    do_cmd("nak_get_bcast", 8'h02, 8'hFF, 64'd0);

    // Inter-byte timeout aborts a partial SET_FINE.
    send_byte(8'h07); send_byte(8'h01); send_byte(8'h34);
    repeat (TOUT + 20) @(negedge clk);
    check("tout_no_tx", 64'(rsp_q.size()), 64'd0);
    check("tout_fine1", 64'(fine_delay_ps[16 +: 16]), 64'd0);
    do_cmd("tout_get_fine", 8'h08, 8'h01, 64'd0);

    // One-shot arming.
    do_cmd("mode_oneshot", 8'h09, 8'h00, 64'd1);
    pulse_fire(4'b0001);
    check("armed_fire1", 64'(armed), 64'b1110);
    pulse_fire(4'b0001);
    check("armed_fire2", 64'(armed), 64'b1110);
    do_cmd("arm_bcast", 8'h0A, 8'hFF, 64'd0);
    check("armed_all", 64'(armed), 64'b1111);

    // Counter saturation, then clear coinciding with a pulse.
    pulse_trig(4'b0010, 259);
    do_cmd("status_sat", 8'h05, 8'h01, 64'd0);
    send_byte(8'h06); send_byte(8'h01);
    trig_pulse = 4'b0010;
    @(negedge clk);
    trig_pulse = '0;
    model_cmd(8'h06, 8'h01, 64'd0);
    wait_reply("rstcnt_ack");
    do_cmd("status_cleared", 8'h05, 8'h01, 64'd0);

    // Randomized command stream against the reference model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) pulse_trig(4'($urandom), $urandom_range(1, 5));
      if ($urandom_range(0, 2) == 0) pulse_fire(4'($urandom));
      r = $urandom_range(0, 10);
      op = (r == 0) ? 8'($urandom_range(11, 255)) : 8'(r);
      r = $urandom_range(0, 9);
      ch = (r < 6) ? 8'($urandom_range(0, NC - 1)) : (r < 8) ? 8'hFF : 8'($urandom_range(NC, 254));
      pay = {$urandom, $urandom};
      if (op == 8'h03 && $urandom_range(0, 1) == 1) pay[7:0] = 8'($urandom_range(0, 3));
      if (op == 8'h09 && $urandom_range(0, 1) == 1) pay[7:0] = 8'd0;
      do_cmd($sformatf("rnd%0d", i), op, ch, pay);
      compare_outputs($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
